// File: rtl/ocpi_wsi_pkg.sv
// Shared OCP/WSI encodings, register map and state type for the WSI delay line.
package ocpi_wsi_pkg;

    localparam logic [2:0] OCP_MCMD_IDLE  = 3'd0;
    localparam logic [2:0] OCP_MCMD_WRITE = 3'd1;
    localparam logic [2:0] OCP_MCMD_READ  = 3'd2;

    localparam logic [1:0] OCP_SRESP_NULL = 2'd0;
    localparam logic [1:0] OCP_SRESP_DVA  = 2'd1;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_DLY    = 8'h04;
    localparam logic [7:0] REG_FILL   = 8'h08;
    localparam logic [7:0] REG_OUTCNT = 8'h0C;
    localparam logic [7:0] REG_DROP   = 8'h10;

    // Word index as seen on MAddr[4:2]
    localparam logic [2:0] IDX_CTRL   = REG_CTRL[4:2];
    localparam logic [2:0] IDX_DLY    = REG_DLY[4:2];
    localparam logic [2:0] IDX_FILL   = REG_FILL[4:2];
    localparam logic [2:0] IDX_OUTCNT = REG_OUTCNT[4:2];
    localparam logic [2:0] IDX_DROP   = REG_DROP[4:2];

    localparam int TS_WIDTH  = 17;
    localparam int DLY_WIDTH = 15;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUN      = 2'd1,
        ST_DRAIN    = 2'd2
    } dl_state_e;

endpackage

// File: rtl/delay_fifo.sv
// Synchronous FIFO holding timestamped WSI words; head entry is visible combinationally.
module delay_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem[rd_ptr_q];

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/wsi_delay_line.sv
// WSI delay worker: buffers each input word with a timestamp and releases it once
// the WCI-programmed delay has elapsed (or immediately in bypass / drain).
module wsi_delay_line
    import ocpi_wsi_pkg::*;
#(
    parameter int         WSI_DATA_WIDTH = 32,
    parameter int         DEPTH          = 64,
    parameter logic [1:0] CTRL_INIT      = 2'b01
) (
    input  logic                          wciS0_Clk,
    input  logic                          wciS0_MReset,
    input  logic [2:0]                    wciS0_MCmd,
    input  logic [31:0]                   wciS0_MAddr,
    input  logic [31:0]                   wciS0_MData,
    output logic [1:0]                    wciS0_SResp,
    output logic [31:0]                   wciS0_SData,
    output logic                          wciS0_SThreadBusy,
    input  logic [2:0]                    wsiS0_MCmd,
    input  logic [WSI_DATA_WIDTH-1:0]     wsiS0_MData,
    input  logic [WSI_DATA_WIDTH/8-1:0]   wsiS0_MByteEn,
    input  logic                          wsiS0_MReqLast,
    input  logic [11:0]                   wsiS0_MBurstLength,
    input  logic [7:0]                    wsiS0_MReqInfo,
    output logic                          wsiS0_SThreadBusy,
    output logic [2:0]                    wsiM0_MCmd,
    output logic [WSI_DATA_WIDTH-1:0]     wsiM0_MData,
    output logic [WSI_DATA_WIDTH/8-1:0]   wsiM0_MByteEn,
    output logic                          wsiM0_MReqLast,
    output logic [11:0]                   wsiM0_MBurstLength,
    output logic [7:0]                    wsiM0_MReqInfo,
    input  logic                          wsiM0_SThreadBusy
);

    localparam int DW        = WSI_DATA_WIDTH;
    localparam int BW        = WSI_DATA_WIDTH / 8;
    localparam int BE_LSB    = DW;
    localparam int LAST_BIT  = DW + BW;
    localparam int BURST_LSB = LAST_BIT + 1;
    localparam int INFO_LSB  = BURST_LSB + 12;
    localparam int TS_LSB    = INFO_LSB + 8;
    localparam int ENTRY_W   = TS_LSB + TS_WIDTH;
    localparam int CW        = $clog2(DEPTH) + 1;

    dl_state_e               state_q, state_d;
    logic [1:0]              ctrl_q, ctrl_d;
    logic [DLY_WIDTH-1:0]    dly_q, dly_d;
    logic [TS_WIDTH-1:0]     now_q, now_d;
    logic [31:0]             out_cnt_q, out_cnt_d;
    logic [31:0]             drop_cnt_q, drop_cnt_d;
    logic                    ripe_q, ripe_d;
    logic [1:0]              sresp_q, sresp_d;
    logic [31:0]             sdata_q, sdata_d;
    logic                    wci_busy_q, wci_busy_d;
    logic [2:0]              om_mcmd_q, om_mcmd_d;
    logic [DW-1:0]           om_data_q, om_data_d;
    logic [BW-1:0]           om_be_q, om_be_d;
    logic                    om_last_q, om_last_d;
    logic [11:0]             om_burst_q, om_burst_d;
    logic [7:0]              om_info_q, om_info_d;

    logic                    wci_accept, wci_wr, wci_rd;
    logic [2:0]              reg_idx;
    logic [31:0]             rdata;
    logic                    in_busy, push, in_drop, pop;
    logic                    drain_now, head_ripe;
    logic [TS_WIDTH-1:0]     age;
    logic [ENTRY_W-1:0]      push_entry, head_entry;
    logic [CW-1:0]           fifo_count;
    logic                    fifo_full, fifo_empty;
    logic                    unused_inputs;

    assign unused_inputs = ^{wciS0_MAddr[31:5], wciS0_MAddr[1:0], wciS0_MData[31:15], fifo_full};

    assign wci_accept = ((wciS0_MCmd == OCP_MCMD_WRITE) || (wciS0_MCmd == OCP_MCMD_READ)) && !wci_busy_q;
    assign wci_wr     = wci_accept && (wciS0_MCmd == OCP_MCMD_WRITE);
    assign wci_rd     = wci_accept && (wciS0_MCmd == OCP_MCMD_READ);
    assign reg_idx    = wciS0_MAddr[4:2];

    assign in_busy = (state_q != ST_RUN) || (fifo_count == CW'(DEPTH));
    assign push    = (wsiS0_MCmd == OCP_MCMD_WRITE) && !in_busy;
    assign in_drop = (wsiS0_MCmd == OCP_MCMD_WRITE) && in_busy;

    assign push_entry = {now_q, wsiS0_MReqInfo, wsiS0_MBurstLength, wsiS0_MReqLast,
                         wsiS0_MByteEn, wsiS0_MData};

    // A disable written while running releases the buffer from that same cycle.
    assign drain_now = (state_q == ST_DRAIN) || ((state_q == ST_RUN) && !ctrl_d[0]);
    assign age       = now_q - head_entry[TS_LSB +: TS_WIDTH];
    assign head_ripe = ripe_q || ctrl_q[1] || drain_now || (age >= {2'b00, dly_q});
    assign pop       = !fifo_empty && head_ripe && !wsiM0_SThreadBusy;

    delay_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (wciS0_Clk),
        .rst       (wciS0_MReset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        ctrl_d = ctrl_q;
        dly_d  = dly_q;
        if (wci_wr) begin
            case (reg_idx)
                IDX_CTRL: ctrl_d = wciS0_MData[1:0];
                IDX_DLY:  dly_d  = wciS0_MData[DLY_WIDTH-1:0];
                default:  ;
            endcase
        end
        rdata = 32'd0;
        case (reg_idx)
            IDX_CTRL:   rdata = {30'd0, ctrl_q};
            IDX_DLY:    rdata = {{(32-DLY_WIDTH){1'b0}}, dly_q};
            IDX_FILL:   rdata = {{(32-CW){1'b0}}, fifo_count};
            IDX_OUTCNT: rdata = out_cnt_q;
            IDX_DROP:   rdata = drop_cnt_q;
            default:    rdata = 32'd0;
        endcase
        sresp_d    = wci_accept ? OCP_SRESP_DVA : OCP_SRESP_NULL;
        sdata_d    = wci_rd ? rdata : 32'd0;
        wci_busy_d = wci_accept;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DISABLED: if (ctrl_d[0]) state_d = ST_RUN;
            ST_RUN:      if (!ctrl_d[0]) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (ctrl_d[0]) begin
                    state_d = ST_RUN;
                end else if (fifo_empty && (om_mcmd_q == OCP_MCMD_IDLE)) begin
                    state_d = ST_DISABLED;
                end
            end
            default:     state_d = ST_DISABLED;
        endcase
    end

    always_comb begin
        now_d      = now_q + 1'b1;
        out_cnt_d  = out_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (pop) begin
            out_cnt_d = out_cnt_q + 32'd1;
        end
        if (in_drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
        // Ripeness sticks to the current head until it leaves.
        ripe_d     = pop ? 1'b0 : (!fifo_empty && head_ripe);
        om_mcmd_d  = pop ? OCP_MCMD_WRITE : OCP_MCMD_IDLE;
        om_data_d  = om_data_q;
        om_be_d    = om_be_q;
        om_last_d  = om_last_q;
        om_burst_d = om_burst_q;
        om_info_d  = om_info_q;
        if (pop) begin
            om_data_d  = head_entry[DW-1:0];
            om_be_d    = head_entry[BE_LSB +: BW];
            om_last_d  = head_entry[LAST_BIT];
            om_burst_d = head_entry[BURST_LSB +: 12];
            om_info_d  = head_entry[INFO_LSB +: 8];
        end
    end

    always_ff @(posedge wciS0_Clk or posedge wciS0_MReset) begin
        if (wciS0_MReset) begin
            state_q    <= ST_DISABLED;
            ctrl_q     <= CTRL_INIT;
            dly_q      <= '0;
            now_q      <= '0;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            ripe_q     <= 1'b0;
            sresp_q    <= OCP_SRESP_NULL;
            sdata_q    <= '0;
            wci_busy_q <= 1'b0;
            om_mcmd_q  <= OCP_MCMD_IDLE;
            om_data_q  <= '0;
            om_be_q    <= '0;
            om_last_q  <= 1'b0;
            om_burst_q <= '0;
            om_info_q  <= '0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            dly_q      <= dly_d;
            now_q      <= now_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ripe_q     <= ripe_d;
            sresp_q    <= sresp_d;
            sdata_q    <= sdata_d;
            wci_busy_q <= wci_busy_d;
            om_mcmd_q  <= om_mcmd_d;
            om_data_q  <= om_data_d;
            om_be_q    <= om_be_d;
            om_last_q  <= om_last_d;
            om_burst_q <= om_burst_d;
            om_info_q  <= om_info_d;
        end
    end

    assign wciS0_SResp        = sresp_q;
    assign wciS0_SData        = sdata_q;
    assign wciS0_SThreadBusy  = wci_busy_q;
    assign wsiS0_SThreadBusy  = in_busy;
    assign wsiM0_MCmd         = om_mcmd_q;
    assign wsiM0_MData        = om_data_q;
    assign wsiM0_MByteEn      = om_be_q;
    assign wsiM0_MReqLast     = om_last_q;
    assign wsiM0_MBurstLength = om_burst_q;
    assign wsiM0_MReqInfo     = om_info_q;

endmodule

// File: tb/tb_wsi_delay_line.sv
// Scoreboard bench for wsi_delay_line: words pushed as expectations when driven,
// checked in order (and on time where the latency is known) when they emerge.
module tb_wsi_delay_line;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  wciS0_MCmd = 3'd0;
    logic [31:0] wciS0_MAddr = 32'd0;
    logic [31:0] wciS0_MData = 32'd0;
    logic [1:0]  wciS0_SResp;
    logic [31:0] wciS0_SData;
    logic        wciS0_SThreadBusy;
    logic [2:0]  wsiS0_MCmd = 3'd0;
    logic [31:0] wsiS0_MData = 32'd0;
    logic [3:0]  wsiS0_MByteEn = 4'd0;
    logic        wsiS0_MReqLast = 1'b0;
    logic [11:0] wsiS0_MBurstLength = 12'd0;
    logic [7:0]  wsiS0_MReqInfo = 8'd0;
    logic        wsiS0_SThreadBusy;
    logic [2:0]  wsiM0_MCmd;
    logic [31:0] wsiM0_MData;
    logic [3:0]  wsiM0_MByteEn;
    logic        wsiM0_MReqLast;
    logic [11:0] wsiM0_MBurstLength;
    logic [7:0]  wsiM0_MReqInfo;
    logic        wsiM0_SThreadBusy = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  be;
        logic        last;
        logic [11:0] burst;
        logic [7:0]  info;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   dummy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wsi_delay_line #(
        .WSI_DATA_WIDTH (32),
        .DEPTH          (8),
        .CTRL_INIT      (2'b01)
    ) dut (
        .wciS0_Clk          (clk),
        .wciS0_MReset       (rst),
        .wciS0_MCmd         (wciS0_MCmd),
        .wciS0_MAddr        (wciS0_MAddr),
        .wciS0_MData        (wciS0_MData),
        .wciS0_SResp        (wciS0_SResp),
        .wciS0_SData        (wciS0_SData),
        .wciS0_SThreadBusy  (wciS0_SThreadBusy),
        .wsiS0_MCmd         (wsiS0_MCmd),
        .wsiS0_MData        (wsiS0_MData),
        .wsiS0_MByteEn      (wsiS0_MByteEn),
        .wsiS0_MReqLast     (wsiS0_MReqLast),
        .wsiS0_MBurstLength (wsiS0_MBurstLength),
        .wsiS0_MReqInfo     (wsiS0_MReqInfo),
        .wsiS0_SThreadBusy  (wsiS0_SThreadBusy),
        .wsiM0_MCmd         (wsiM0_MCmd),
        .wsiM0_MData        (wsiM0_MData),
        .wsiM0_MByteEn      (wsiM0_MByteEn),
        .wsiM0_MReqLast     (wsiM0_MReqLast),
        .wsiM0_MBurstLength (wsiM0_MBurstLength),
        .wsiM0_MReqInfo     (wsiM0_MReqInfo),
        .wsiM0_SThreadBusy  (wsiM0_SThreadBusy)
    );

    // Output monitor: every emitted word must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && wsiM0_MCmd == 3'd1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL out_unexpected: got data %h at cycle %0d, want no word", wsiM0_MData, cyc);
            end else begin
                e = sb.pop_front();
                if ({wsiM0_MData, wsiM0_MByteEn, wsiM0_MReqLast, wsiM0_MBurstLength, wsiM0_MReqInfo}
                    !== {e.data, e.be, e.last, e.burst, e.info}) begin
                    errors++;
                    $display("[TB] FAIL out_word: got %h/%h/%b/%h/%h want %h/%h/%b/%h/%h",
                             wsiM0_MData, wsiM0_MByteEn, wsiM0_MReqLast, wsiM0_MBurstLength, wsiM0_MReqInfo,
                             e.data, e.be, e.last, e.burst, e.info);
                end
                if (e.due >= 0) begin
                    checks++;
                    if (cyc != e.due) begin
                        errors++;
                        $display("[TB] FAIL out_time: word %h got cycle %0d want cycle %0d", e.data, cyc, e.due);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wciS0_MCmd = 3'd0;
        wsiS0_MCmd = 3'd0;
        wsiM0_SThreadBusy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic wci_write(input logic [31:0] addr, input logic [31:0] data, output int acc_cyc);
        int n = 0;
        tick();
        while (wciS0_SThreadBusy && n < 10) begin
            tick();
            n++;
        end
        wciS0_MCmd  = 3'd1;
        wciS0_MAddr = addr;
        wciS0_MData = data;
        acc_cyc     = cyc;
        tick();
        wciS0_MCmd  = 3'd0;
    endtask

    task automatic wci_read(input logic [31:0] addr, output logic [1:0] resp,
                            output logic [31:0] data, output logic busy);
        int n = 0;
        tick();
        while (wciS0_SThreadBusy && n < 10) begin
            tick();
            n++;
        end
        wciS0_MCmd  = 3'd2;
        wciS0_MAddr = addr;
        tick();
        wciS0_MCmd  = 3'd0;
        resp = wciS0_SResp;
        data = wciS0_SData;
        busy = wciS0_SThreadBusy;
    endtask

    task automatic send_word(input int idx, input bit expect_accept, input int due_off);
        exp_t e;
        tick();
        wsiS0_MCmd         = 3'd1;
        wsiS0_MData        = 32'hA0 + 32'(idx);
        wsiS0_MByteEn      = 4'(idx + 1);
        wsiS0_MReqLast     = (idx % 4 == 3);
        wsiS0_MBurstLength = 12'(idx + 4);
        wsiS0_MReqInfo     = 8'h40 + 8'(idx);
        if (expect_accept) begin
            e.data  = wsiS0_MData;
            e.be    = wsiS0_MByteEn;
            e.last  = wsiS0_MReqLast;
            e.burst = wsiS0_MBurstLength;
            e.info  = wsiS0_MReqInfo;
            e.due   = (due_off < 0) ? -1 : cyc + due_off;
            sb.push_back(e);
        end
    endtask

    task automatic idle_in();
        tick();
        wsiS0_MCmd = 3'd0;
    endtask

    task automatic wait_empty(input int budget, output bit ok);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        ok = (sb.size() == 0);
    endtask

    task automatic test_reset();
        logic [31:0] addrs [5];
        logic [31:0] want  [5];
        logic [1:0]  resp;
        logic [31:0] rd;
        logic        bz;
        addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};
        want  = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
        do_reset();
        checks++;
        if ({wsiM0_MCmd, wsiM0_MData, wsiS0_SThreadBusy, wciS0_SResp, wciS0_SData, wciS0_SThreadBusy}
            !== {3'd0, 32'd0, 1'b1, 2'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got mcmd=%0d data=%h ibusy=%b sresp=%0d sdata=%h wbusy=%b want 0/0/1/0/0/0",
                     wsiM0_MCmd, wsiM0_MData, wsiS0_SThreadBusy, wciS0_SResp, wciS0_SData, wciS0_SThreadBusy);
        end
        for (int i = 0; i < 5; i++) begin
            wci_read(addrs[i], resp, rd, bz);
            checks++;
            if (rd !== want[i] || resp !== 2'd1) begin
                errors++;
                $display("[TB] FAIL reset_reg_%h: got %h resp %0d want %h resp 1", addrs[i], rd, resp, want[i]);
            end
        end
    endtask

    task automatic test_delay();
        logic [1:0]  resp;
        logic [31:0] rd;
        logic        bz;
        bit          ok;
        do_reset();
        wci_write(32'h04, 32'd10, dummy);
        checks++;
        if (wsiS0_SThreadBusy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL run_ready: input busy got %b want 0", wsiS0_SThreadBusy);
        end
        for (int i = 0; i < 4; i++) send_word(i, 1'b1, 11);
        idle_in();
        wait_empty(40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL delay_timeout: %0d words still pending want 0", sb.size());
        end
        wci_read(32'h0C, resp, rd, bz);
        checks++;
        if (rd !== 32'd4) begin
            errors++;
            $display("[TB] FAIL delay_outcnt: got %0d want 4", rd);
        end
    endtask

    task automatic test_bypass();
        bit ok;
        do_reset();
        wci_write(32'h00, 32'd3, dummy);
        wci_write(32'h04, 32'd500, dummy);
        send_word(7, 1'b1, 2);
        idle_in();
        wait_empty(10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL bypass_timeout: %0d words pending want 0", sb.size());
        end
    endtask

    task automatic test_overflow();
        logic [1:0]  resp;
        logic [31:0] rd;
        logic        bz;
        bit          ok;
        do_reset();
        wsiM0_SThreadBusy = 1'b1;
        for (int i = 0; i < 10; i++) send_word(i, i < 8, -1);
        idle_in();
        checks++;
        if (wsiS0_SThreadBusy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_busy: input busy got %b want 1", wsiS0_SThreadBusy);
        end
        wci_read(32'h08, resp, rd, bz);
        checks++;
        if (rd !== 32'd8) begin
            errors++;
            $display("[TB] FAIL full_fill: got %0d want 8", rd);
        end
        wci_read(32'h10, resp, rd, bz);
        checks++;
        if (rd !== 32'd2) begin
            errors++;
            $display("[TB] FAIL full_drop: got %0d want 2", rd);
        end
        wsiM0_SThreadBusy = 1'b0;
        wait_empty(40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL full_timeout: %0d words pending want 0", sb.size());
        end
        wci_read(32'h0C, resp, rd, bz);
        checks++;
        if (rd !== 32'd8) begin
            errors++;
            $display("[TB] FAIL full_outcnt: got %0d want 8", rd);
        end
    endtask

    task automatic test_drain();
        logic [1:0]  resp;
        logic [31:0] rd;
        logic        bz;
        bit          ok;
        int          k0;
        int          w;
        do_reset();
        wci_write(32'h04, 32'd1000, dummy);
        send_word(0, 1'b1, -1);
        k0 = cyc;
        send_word(1, 1'b1, -1);
        send_word(2, 1'b1, -1);
        idle_in();
        while (cyc < k0 + 4) tick();
        wci_write(32'h00, 32'd0, w);
        for (int i = 0; i < sb.size(); i++) sb[i].due = w + 1 + i;
        wait_empty(10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL drain_timeout: %0d words pending want 0", sb.size());
        end
        repeat (3) tick();
        checks++;
        if (wsiS0_SThreadBusy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drain_busy: input busy got %b want 1", wsiS0_SThreadBusy);
        end
        wci_read(32'h08, resp, rd, bz);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("[TB] FAIL drain_fill: got %0d want 0", rd);
        end
    endtask

    task automatic test_wci();
        logic [1:0]  resp;
        logic [31:0] rd;
        logic        bz;
        do_reset();
        wci_write(32'h04, 32'h1234, dummy);
        wci_read(32'h04, resp, rd, bz);
        checks++;
        if (resp !== 2'd1 || rd !== 32'h1234 || bz !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wci_dly_read: got resp %0d data %h busy %b want 1 00001234 1", resp, rd, bz);
        end
        tick();
        checks++;
        if (wciS0_SResp !== 2'd0 || wciS0_SThreadBusy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wci_idle: got resp %0d busy %b want 0 0", wciS0_SResp, wciS0_SThreadBusy);
        end
        send_word(0, 1'b1, -1);
        send_word(1, 1'b1, -1);
        idle_in();
        wci_write(32'h08, 32'hFF, dummy);
        wci_read(32'h08, resp, rd, bz);
        checks++;
        if (rd !== 32'd2) begin
            errors++;
            $display("[TB] FAIL wci_ro_fill: got %0d want 2", rd);
        end
        wci_read(32'h1C, resp, rd, bz);
        checks++;
        if (rd !== 32'd0 || resp !== 2'd1) begin
            errors++;
            $display("[TB] FAIL wci_unmapped: got %h resp %0d want 0 resp 1", rd, resp);
        end
    endtask

    task automatic test_reset_midstream();
        logic [1:0]  resp;
        logic [31:0] rd;
        logic        bz;
        bit          ok;
        do_reset();
        wci_write(32'h04, 32'd1000, dummy);
        for (int i = 0; i < 5; i++) send_word(i, 1'b1, -1);
        idle_in();
        wci_read(32'h08, resp, rd, bz);
        checks++;
        if (rd !== 32'd5) begin
            errors++;
            $display("[TB] FAIL mid_fill_before: got %0d want 5", rd);
        end
        tick();
        rst = 1'b1;
        #1;
        sb.delete();
        checks++;
        if (wsiM0_MCmd !== 3'd0 || wsiS0_SThreadBusy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_out: got mcmd %0d ibusy %b want 0 1", wsiM0_MCmd, wsiS0_SThreadBusy);
        end
        tick();
        rst = 1'b0;
        wci_read(32'h08, resp, rd, bz);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("[TB] FAIL mid_fill_after: got %0d want 0", rd);
        end
        wci_read(32'h00, resp, rd, bz);
        checks++;
        if (rd !== 32'd1) begin
            errors++;
            $display("[TB] FAIL mid_ctrl: got %h want 1", rd);
        end
        wci_read(32'h04, resp, rd, bz);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("[TB] FAIL mid_dly: got %0d want 0", rd);
        end
        send_word(9, 1'b1, 2);
        idle_in();
        wait_empty(10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL mid_timeout: %0d words pending want 0", sb.size());
        end
        repeat (20) tick();
    endtask

    initial begin
        test_reset();
        test_delay();
        test_bypass();
        test_overflow();
        test_drain();
        test_wci();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wsi_delay_line.md
# wsi_delay_line

Parametrised WSI stream delay worker: accepts words on a WSI slave, holds each in an on-chip timestamped FIFO and releases it on a WSI master once a WCI-programmed cycle delay has elapsed. Data width and buffer depth are parameters rather than per-width variants. Adds a bypass mode, a drain-on-disable state machine, and fill/throughput/overflow counters. Sits between two WSI workers inside an OCPI application, controlled by the platform WCI.

## Interface
- WSI_DATA_WIDTH, 32, WSI data width; legal values 32, 64, 128, 256
- DEPTH, 64, FIFO entries; power of two, 4..1024
- CTRL_INIT, 1, reset value of ctrl register bits [1:0]
- wciS0_Clk  in  1  sole clock
- wciS0_MReset  in  1  asynchronous, active-high reset
- wciS0_MCmd  in  3  0 idle, 1 write, 2 read
- wciS0_MAddr  in  32  byte address; bits [4:2] decoded
- wciS0_MData  in  32  write data
- wciS0_SResp  out  2  0 null, 1 DVA
- wciS0_SData  out  32  read data
- wciS0_SThreadBusy  out  1  high during the response cycle
- wsiS0_MCmd  in  3  0 idle, 1 write
- wsiS0_MData  in  WSI_DATA_WIDTH  payload
- wsiS0_MByteEn  in  WSI_DATA_WIDTH/8  byte enables
- wsiS0_MReqLast  in  1  last word of message
- wsiS0_MBurstLength  in  12  burst length
- wsiS0_MReqInfo  in  8  opcode
- wsiS0_SThreadBusy  out  1  input backpressure
- wsiM0_MCmd, wsiM0_MData, wsiM0_MByteEn, wsiM0_MReqLast, wsiM0_MBurstLength, wsiM0_MReqInfo  out  same widths as wsiS0  output word
- wsiM0_SThreadBusy  in  1  downstream backpressure

## Operation
- Registers, byte offsets: 0x00 ctrl (bit0 enable, bit1 bypass), 0x04 dly (bits [14:0], 0..32767), 0x08 fill level (RO), 0x0C words-out count (RO, 32-bit, wraps), 0x10 drop count (RO, 32-bit, saturates). Writes to RO or unmapped offsets are ignored. Unmapped reads return 0.
- WCI command is accepted when SThreadBusy is low. The following cycle carries SResp=DVA with SData, and SThreadBusy is high, giving at most one command every 2 cycles.
- Free-running 17-bit counter `now`. Each accepted input word is written with ts=now together with data, byteEn, reqLast, burstLength and reqInfo.
- Input accepted when wsiS0_MCmd=1 and wsiS0_SThreadBusy=0. wsiS0_SThreadBusy is high when state!=RUN or count==DEPTH. Write while busy: word dropped, drop count +1.
- Head is ripe when (now−ts) mod 2^17 ≥ dly, or bypass=1, or state=DRAIN. Ripe is latched until pop. A word may wait ≥2^17 cycles behind the head; that case is unsupported.
- Pop when head ripe, FIFO non-empty and wsiM0_SThreadBusy=0. The output register is loaded with the head word and MCmd=1 for exactly one cycle, then returns to MCmd=0. Words-out count +1.
- State machine:
  - DISABLED → RUN when enable=1.
  - RUN → DRAIN when enable is written 0.
  - DRAIN → DISABLED when FIFO is empty and the output register is idle.
  - DRAIN → RUN if enable is rewritten 1.
- Simultaneous push and pop: count unchanged. Pop with count==DEPTH frees a slot only from the next cycle.
- Changing dly mid-stream affects all non-latched entries immediately.

## Timing
- Latency from input-accept cycle t to wsiM0_MCmd=1: max(dly,1)+1 cycles with no backpressure. Bypass: 2 cycles.
- Throughput: 1 word/cycle sustained.
- Reset (async assert, sync deassert):
  - state DISABLED, FIFO empty, counters 0, now=0.
  - ctrl=CTRL_INIT, dly=0.
  - wsiM0_MCmd=0, other wsiM0 outputs 0.
  - wsiS0_SThreadBusy=1, SResp=0, SData=0, wciS0_SThreadBusy=0.
  - Reset mid-stream discards all buffered words.
- The output never skips or reorders words.

## Structure
- Package ocpi_wsi_pkg: MCmd encodings, SResp encodings, register offsets, state enum, TS_WIDTH=17.
- Sub-module delay_fifo: synchronous FIFO (DEPTH × entry), push/pop, count, full/empty. Entry width is WSI_DATA_WIDTH+WSI_DATA_WIDTH/8+1+12+8+17.
- Top level holds the WCI register file, state machine, ripe logic, output register and counters.

## Test plan
- dly=10, enable=1, 4 back-to-back words 0xA0..0xA3 at t=0..3 → wsiM0_MCmd=1 at t=11..14, same data and order; words-out=4.
- bypass=1, dly=500, one word at t=0 → output at t=2.
- dly=0, DEPTH=8, wsiM0_SThreadBusy held high, 10 words forced (ignoring busy) → fill=8, drop=2; release busy → exactly 8 words out in order.
- dly=1000, 3 words buffered, write ctrl enable=0 at t=5 → all 3 out by t=8, state DISABLED, wsiS0_SThreadBusy=1.
- WCI: write 0x04=0x1234, read 0x04 → SResp=DVA next cycle, SData=0x1234, SThreadBusy=1 that cycle; write 0x08 → fill unchanged.
- Assert reset with 5 words buffered → next cycle wsiM0_MCmd=0, fill=0, ctrl=CTRL_INIT, no stale word emitted after reset release.
